ibram_arbiter: RTL and testbench
================================

IBRAM_ARBITER -- requirements
Module: ibram_arbiter

Interface
REQ-001 ADDR_WIDTH, default 10, BRAM word-address width.
REQ-002 DATA_WIDTH, default 32, BRAM word width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester beat valid (bit 0 = requester 0, bit 1 = requester 1).
REQ-006 req_write  input  2  per-requester beat is write (1) / read (0).
REQ-007 req_last  input  2  per-requester beat ends burst; 0 requests bus lock.
REQ-008 req_addr  input  2*ADDR_WIDTH  per-requester word address, requester n at [n*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_wdata  input  2*DATA_WIDTH  per-requester write data, same slicing.
REQ-010 req_ready  output  2  per-requester beat accepted this cycle when valid.
REQ-011 resp_valid  output  2  per-requester read data valid.
REQ-012 resp_rdata  output  DATA_WIDTH  read data, shared, qualified by resp_valid.
REQ-013 bram_en  output  1  BRAM port enable.
REQ-014 bram_we  output  1  BRAM port write enable.
REQ-015 bram_addr  output  ADDR_WIDTH  BRAM port address.
REQ-016 bram_wdata  output  DATA_WIDTH  BRAM port write data.
REQ-017 bram_rdata  input  DATA_WIDTH  BRAM port read data, 1-cycle read latency, write-first.

Function
REQ-018 Handshake: beat of n transfers when req_valid[n] & req_ready[n]; req_ready combinational from state, pointer and req_valid; requester holds valid/write/last/addr/wdata stable while valid & !ready.
REQ-019 At most one req_ready bit high per cycle; req_ready[n] never high unless req_valid[n] high.
REQ-020 States IDLE, OWN0, OWN1; reset state IDLE.
REQ-021 IDLE: single valid requester granted regardless of pointer; both valid -> requester named by priority pointer granted.
REQ-022 IDLE: granted beat with req_last=0 -> OWNn next cycle; with req_last=1 -> stay IDLE.
REQ-023 OWNn: only requester n grantable; other requester's ready held 0 even if owner idle (bubble, no timeout).
REQ-024 OWNn: accepted beat with req_last=1 -> IDLE next cycle.
REQ-025 Priority pointer: 1 bit, reset 0; on accepted beat with req_last=1 from n, pointer <= 1-n; otherwise unchanged.
REQ-026 bram_en = any handshake; bram_we = handshake & req_write of granted requester; bram_addr/bram_wdata = granted requester's fields, combinational, zero when no grant.
REQ-027 Read handshake of n in cycle t -> resp_valid[n]=1 in cycle t+1 exactly, resp_rdata = bram_rdata in t+1; resp_valid otherwise 0; writes produce no response.
REQ-028 No response backpressure; requester must consume resp in its valid cycle.
REQ-029 Throughput one beat per cycle; back-to-back beats (same or alternating requesters) with no bubbles.
REQ-030 Write then read of same address in consecutive cycles returns new data (BRAM write-first); arbiter adds no forwarding or reordering.
REQ-031 resp_rdata when resp_valid all-zero: don't-care, but no X-propagation into resp_valid.

Reset
REQ-032 While resetn=0: req_ready=0, bram_en=0, bram_we=0; next cycle state IDLE, pointer 0, resp_valid=0.
REQ-033 Reset mid-burst aborts lock; read accepted in cycle before reset asserted produces no resp_valid in the reset cycle.
REQ-034 First cycle after resetn rises: arbitration proceeds normally from IDLE, pointer 0.

Verification
REQ-035 Both valid single-beat reads (r0 addr 0x004, r1 addr 0x008, last=1) from reset -> cycle 0 grant 0, cycle 1 grant 1; resp_valid=2'b01 cycle 1, 2'b10 cycle 2 with stored data.
REQ-036 r1 burst 4 reads addr 0x010..0x013 (last on 4th) while r0 valid -> r0 ready 0 for 4 cycles, r0 granted cycle 5, pointer then 1.
REQ-037 r0 write 0xDEADBEEF @0x020 then read @0x020 next cycle -> resp_valid[0] returns 0xDEADBEEF.
REQ-038 r1 lock (last=0) then drops valid 3 cycles with r0 valid -> no grants, bram_en=0 for 3 cycles, lock persists.
REQ-039 resetn low during OWN1 with read handshake previous cycle -> resp_valid=0, state IDLE, r0 granted first after release.
REQ-040 Random constrained traffic 10k cycles against reference memory model -> every read data match, no grant while other owns lock, one grant per cycle max.

Source files
------------

// File: rtl/ibram_arbiter_if.sv
// Requester-side and BRAM-side signal bundle for the two-port block RAM arbiter.
interface ibram_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]              req_valid;
  logic [1:0]              req_write;
  logic [1:0]              req_last;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [1:0]              req_ready;
  logic [1:0]              resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    bram_en;
  logic                    bram_we;
  logic [ADDR_WIDTH-1:0]   bram_addr;
  logic [DATA_WIDTH-1:0]   bram_wdata;
  logic [DATA_WIDTH-1:0]   bram_rdata;

  // Arbiter side
  modport slave (
    input  req_valid, req_write, req_last, req_addr, req_wdata, bram_rdata,
    output req_ready, resp_valid, resp_rdata,
    output bram_en, bram_we, bram_addr, bram_wdata
  );

  // Requesters plus BRAM side
  modport master (
    output req_valid, req_write, req_last, req_addr, req_wdata, bram_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  bram_en, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/ibram_arbiter.sv
// Two-requester arbiter for a single BRAM port: round-robin pointer in idle,
// bus lock while a burst (req_last=0) is in progress, one-cycle read response.
module ibram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          resetn,
  ibram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t     state;
  logic       ptr;
  logic [1:0] resp_q;
  logic [1:0] grant;
  logic       gnt_sel;
  logic       hs;

  // Grant selection from state, priority pointer and current valids
  always_comb begin
    grant = '0;
    if (resetn) begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
          else                        grant = bus.req_valid;
        end
        OWN0:    grant = {1'b0, bus.req_valid[0]};
        OWN1:    grant = {bus.req_valid[1], 1'b0};
        default: grant = '0;
      endcase
    end
  end

  assign gnt_sel = grant[1];
  assign hs      = |grant;

  // BRAM port driven straight from the granted requester, zero otherwise
  assign bus.req_ready  = grant;
  assign bus.bram_en    = hs;
  assign bus.bram_we    = hs & bus.req_write[gnt_sel];
  assign bus.bram_addr  = !hs    ? '0 :
                          gnt_sel ? bus.req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                  : bus.req_addr[0 +: ADDR_WIDTH];
  assign bus.bram_wdata = !hs    ? '0 :
                          gnt_sel ? bus.req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                  : bus.req_wdata[0 +: DATA_WIDTH];

  // Gated by resetn so a read accepted just before reset never reports
  // during the reset cycle itself.
  assign bus.resp_valid = resp_q & {2{resetn}};
  assign bus.resp_rdata = bus.bram_rdata;

  // Lock/pointer state machine and registered read-response flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      resp_q <= '0;
    end else begin
      resp_q <= grant & ~bus.req_write;
      if (hs) begin
        if (bus.req_last[gnt_sel]) begin
          state <= IDLE;
          ptr   <= ~gnt_sel;
        end else begin
          state <= gnt_sel ? OWN1 : OWN0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibram_arbiter.sv
// Testbench for ibram_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbitration and memory model.
module tb_ibram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk;
  logic resetn;

  ibram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ibram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vectors;
  int miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM behaviour: one-cycle read latency, write-first
  logic [DW-1:0] bram_mem [1024];
  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) begin
        bram_mem[bus.bram_addr] = bus.bram_wdata;
        bus.bram_rdata <= bus.bram_wdata;
      end else begin
        bus.bram_rdata <= bram_mem[bus.bram_addr];
      end
    end
  end

  // Reference model: lock owner (-1 = none), pointer, shadow memory, pending responses
  int            owner;
  bit            mptr;
  logic [DW-1:0] ref_mem [1024];
  logic [1:0]    exp_rv;
  logic [DW-1:0] exp_rd [2];

  function automatic int exp_grant();
    if (resetn !== 1'b1) return -1;
    if (owner >= 0) return bus.req_valid[owner] ? owner : -1;
    if (bus.req_valid == 2'b11) return int'(mptr);
    if (bus.req_valid[0]) return 0;
    if (bus.req_valid[1]) return 1;
    return -1;
  endfunction

  function automatic logic [AW-1:0] req_addr_of(input int n);
    return bus.req_addr[n*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] req_wdata_of(input int n);
    return bus.req_wdata[n*DW +: DW];
  endfunction

  always @(posedge clk) begin : model
    int g;
    logic [1:0] nrv;
    g   = exp_grant();
    nrv = 2'b00;
    if (resetn !== 1'b1) begin
      owner = -1;
      mptr  = 1'b0;
    end else if (g >= 0) begin
      if (bus.req_write[g]) begin
        ref_mem[req_addr_of(g)] = req_wdata_of(g);
      end else begin
        nrv[g]    = 1'b1;
        exp_rd[g] = ref_mem[req_addr_of(g)];
      end
      if (bus.req_last[g]) begin
        owner = -1;
        mptr  = (g == 0);
      end else begin
        owner = g;
      end
    end
    exp_rv = nrv;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input bit v, input bit w, input bit l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[n]        = v;
    bus.req_write[n]        = w;
    bus.req_last[n]         = l;
    bus.req_addr[n*AW +: AW] = a;
    bus.req_wdata[n*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    set_req(0, 0, 0, 1, '0, '0);
    set_req(1, 0, 0, 1, '0, '0);
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_req(0, 1, 0, 1, AW'(4), '0);
    set_req(1, 1, 1, 1, AW'(8), 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_ready: got %b expected 00", bus.req_ready);
      end
      vectors++;
      if (bus.bram_en !== 1'b0 || bus.bram_we !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_bram: got en=%b we=%b expected 0 0", bus.bram_en, bus.bram_we);
      end
      vectors++;
      if (i > 0 && bus.resp_valid !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_resp: got %b expected 00", bus.resp_valid);
      end
      tick();
    end
    set_req(0, 0, 0, 1, '0, '0);
    set_req(1, 0, 0, 1, '0, '0);
  endtask

  task automatic test_priority();
    apply_reset();
    set_req(0, 1, 0, 1, AW'(4), '0);
    set_req(1, 1, 0, 1, AW'(8), '0);
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 2'b01 || bus.bram_addr !== AW'(4)) begin
      miscompares++;
      $display("FAIL prio_c0: got ready=%b addr=%h expected 01 004", bus.req_ready, bus.bram_addr);
    end
    tick();
    set_req(0, 0, 0, 1, '0, '0);
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 2'b10 || bus.bram_addr !== AW'(8)) begin
      miscompares++;
      $display("FAIL prio_c1: got ready=%b addr=%h expected 10 008", bus.req_ready, bus.bram_addr);
    end
    vectors++;
    if (bus.resp_valid !== 2'b01 || bus.resp_rdata !== ref_mem[4]) begin
      miscompares++;
      $display("FAIL prio_resp0: got rv=%b data=%h expected 01 %h", bus.resp_valid, bus.resp_rdata, ref_mem[4]);
    end
    tick();
    set_req(1, 0, 0, 1, '0, '0);
    @(negedge clk);
    vectors++;
    if (bus.resp_valid !== 2'b10 || bus.resp_rdata !== ref_mem[8]) begin
      miscompares++;
      $display("FAIL prio_resp1: got rv=%b data=%h expected 10 %h", bus.resp_valid, bus.resp_rdata, ref_mem[8]);
    end
    tick();
  endtask

  task automatic test_burst_lock();
    apply_reset();
    set_req(0, 1, 0, 1, AW'('h30), '0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1, 0, (i == 3), AW'('h10 + i), '0);
      set_req(0, 1, 0, 1, AW'('h40), '0);
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== 2'b10 || bus.bram_addr !== AW'('h10 + i)) begin
        miscompares++;
        $display("FAIL burst_beat%0d: got ready=%b addr=%h expected 10 %h", i, bus.req_ready, bus.bram_addr, AW'('h10 + i));
      end
      vectors++;
      if (i > 0 && (bus.resp_valid !== 2'b10 || bus.resp_rdata !== ref_mem['h10 + i - 1])) begin
        miscompares++;
        $display("FAIL burst_resp%0d: got rv=%b data=%h expected 10 %h", i, bus.resp_valid, bus.resp_rdata, ref_mem['h10 + i - 1]);
      end
      tick();
    end
    set_req(1, 0, 0, 1, '0, '0);
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL burst_r0_after: got %b expected 01", bus.req_ready);
    end
    tick();
    set_req(0, 1, 0, 1, AW'('h41), '0);
    set_req(1, 1, 0, 1, AW'('h42), '0);
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL burst_pointer: got %b expected 10", bus.req_ready);
    end
    tick();
    set_req(0, 0, 0, 1, '0, '0);
    set_req(1, 0, 0, 1, '0, '0);
    tick();
  endtask

  task automatic test_write_read();
    apply_reset();
    set_req(0, 1, 1, 1, AW'('h20), 32'hDEAD_BEEF);
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 2'b01 || bus.bram_we !== 1'b1 || bus.bram_addr !== AW'('h20) ||
        bus.bram_wdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL wr_beat: got ready=%b we=%b addr=%h wd=%h expected 01 1 020 deadbeef",
               bus.req_ready, bus.bram_we, bus.bram_addr, bus.bram_wdata);
    end
    tick();
    set_req(0, 1, 0, 1, AW'('h20), '0);
    @(negedge clk);
    vectors++;
    if (bus.resp_valid !== 2'b00 || bus.bram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_no_resp: got rv=%b we=%b expected 00 0", bus.resp_valid, bus.bram_we);
    end
    tick();
    set_req(0, 0, 0, 1, '0, '0);
    @(negedge clk);
    vectors++;
    if (bus.resp_valid !== 2'b01 || bus.resp_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rd_after_wr: got rv=%b data=%h expected 01 deadbeef", bus.resp_valid, bus.resp_rdata);
    end
    tick();
  endtask

  task automatic test_lock_bubble();
    apply_reset();
    set_req(1, 1, 0, 0, AW'('h50), '0);
    tick();
    set_req(1, 0, 0, 0, '0, '0);
    set_req(0, 1, 0, 1, AW'('h60), '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== 2'b00 || bus.bram_en !== 1'b0) begin
        miscompares++;
        $display("FAIL bubble%0d: got ready=%b en=%b expected 00 0", i, bus.req_ready, bus.bram_en);
      end
      tick();
    end
    set_req(1, 1, 0, 1, AW'('h51), '0);
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL lock_persist: got %b expected 10", bus.req_ready);
    end
    tick();
    set_req(1, 0, 0, 1, '0, '0);
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL lock_release: got %b expected 01", bus.req_ready);
    end
    tick();
    set_req(0, 0, 0, 1, '0, '0);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req(1, 1, 0, 0, AW'('h70), '0);
    tick();
    set_req(1, 1, 0, 0, AW'('h71), '0);
    set_req(0, 1, 0, 1, AW'('h72), '0);
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL mid_own1: got %b expected 10", bus.req_ready);
    end
    tick();
    resetn = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.resp_valid !== 2'b00 || bus.req_ready !== 2'b00 || bus.bram_en !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got rv=%b ready=%b en=%b expected 00 00 0", bus.resp_valid, bus.req_ready, bus.bram_en);
    end
    tick();
    resetn = 1'b1;
    set_req(1, 1, 0, 1, AW'('h73), '0);
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 2'b01 || bus.resp_valid !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_release: got ready=%b rv=%b expected 01 00", bus.req_ready, bus.resp_valid);
    end
    tick();
    set_req(0, 0, 0, 1, '0, '0);
    set_req(1, 0, 0, 1, '0, '0);
    tick();
  endtask

  task automatic test_random();
    logic [1:0] hold;
    int g;
    logic [1:0] er;
    apply_reset();
    hold = 2'b00;
    for (int c = 0; c < 10000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          set_req(n, ($urandom_range(3, 0) != 0), $urandom_range(1, 0) == 1,
                  ($urandom_range(2, 0) != 0), AW'($urandom_range(63, 0)), DW'($urandom()));
        end
      end
      @(negedge clk);
      g  = exp_grant();
      er = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
      vectors++;
      if (bus.req_ready !== er) begin
        miscompares++;
        $display("FAIL rnd_ready c%0d: got %b expected %b", c, bus.req_ready, er);
      end
      vectors++;
      if ((bus.req_ready & ~bus.req_valid) !== 2'b00 || bus.req_ready === 2'b11) begin
        miscompares++;
        $display("FAIL rnd_onehot c%0d: got ready=%b valid=%b", c, bus.req_ready, bus.req_valid);
      end
      vectors++;
      if (bus.bram_en !== (g >= 0)) begin
        miscompares++;
        $display("FAIL rnd_en c%0d: got %b expected %b", c, bus.bram_en, (g >= 0));
      end
      vectors++;
      if (g >= 0 && (bus.bram_we !== bus.req_write[g] || bus.bram_addr !== req_addr_of(g) ||
                     bus.bram_wdata !== req_wdata_of(g))) begin
        miscompares++;
        $display("FAIL rnd_bram c%0d: got we=%b addr=%h wd=%h expected %b %h %h", c,
                 bus.bram_we, bus.bram_addr, bus.bram_wdata, bus.req_write[g], req_addr_of(g), req_wdata_of(g));
      end
      vectors++;
      if (g < 0 && (bus.bram_we !== 1'b0 || bus.bram_addr !== '0 || bus.bram_wdata !== '0)) begin
        miscompares++;
        $display("FAIL rnd_bram_idle c%0d: got we=%b addr=%h wd=%h expected zero", c,
                 bus.bram_we, bus.bram_addr, bus.bram_wdata);
      end
      vectors++;
      if (bus.resp_valid !== exp_rv) begin
        miscompares++;
        $display("FAIL rnd_rv c%0d: got %b expected %b", c, bus.resp_valid, exp_rv);
      end
      for (int n = 0; n < 2; n++) begin
        if (exp_rv[n]) begin
          vectors++;
          if (bus.resp_rdata !== exp_rd[n]) begin
            miscompares++;
            $display("FAIL rnd_rdata c%0d r%0d: got %h expected %h", c, n, bus.resp_rdata, exp_rd[n]);
          end
        end
      end
      hold = bus.req_valid & ~bus.req_ready;
      tick();
    end
    set_req(0, 0, 0, 1, '0, '0);
    set_req(1, 0, 0, 1, '0, '0);
    tick();
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    owner       = -1;
    mptr        = 1'b0;
    exp_rv      = 2'b00;
    exp_rd[0]   = '0;
    exp_rd[1]   = '0;
    bus.bram_rdata = '0;
    for (int i = 0; i < 1024; i++) begin
      bram_mem[i] = DW'(i) * 32'h0101_0101 ^ 32'hA5C3_0F96;
      ref_mem[i]  = bram_mem[i];
    end
    resetn = 1'b0;
    set_req(0, 0, 0, 1, '0, '0);
    set_req(1, 0, 0, 1, '0, '0);
    tick();
    test_reset();
    test_priority();
    test_burst_lock();
    test_write_read();
    test_lock_bubble();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
